program_loader: RTL and testbench

Front-end loader that sits upstream of the 8-bit CPU's 16-byte RAM. Before the CPU runs, it accepts a program byte-by-byte from the dedicated input pins over a four-phase strobe/ack handshake and writes each byte into RAM at consecutive addresses. It holds the CPU core in reset until the load completes or is skipped.

---
 rtl/program_loader_pkg.sv | 17 +
 rtl/sync_edge.sv | 29 ++
 rtl/program_loader.sv | 136 +++++++++++++
 tb/tb_program_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader, its RAM and the CPU top level.
package program_loader_pkg;

  localparam int unsigned RAM_BYTES_DEF   = 16;
  localparam int unsigned ADDR_W_DEF      = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned DATA_W          = 8;

  typedef enum logic [2:0] {
    CHECK,
    WAIT_HI,
    WRITE,
    WAIT_LO,
    RUN
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, with a rising-edge flag
// taken from the last synchronized stage.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic sync,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync   = sync_q[SYNC_STAGES-1];
  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/program_loader.sv
// Loads a program byte-by-byte into CPU RAM over a strobe/ack handshake and
// holds the CPU in reset until the load completes, aborts or is skipped.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned RAM_BYTES   = RAM_BYTES_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              strobe,
  input  logic [DATA_W-1:0] data_in,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ack,
  output logic              cpu_hold_n,
  output logic              done
);

  localparam int unsigned       CNT_W     = $clog2(SYNC_STAGES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);

  logic strobe_s;
  logic strobe_rise_c;
  logic load_s;
  logic load_rise_unused_c;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_strobe_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (strobe),
    .sync   (strobe_s),
    .rise_c (strobe_rise_c)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (load_en),
    .sync   (load_s),
    .rise_c (load_rise_unused_c)
  );

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ram_we_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_d;
  logic              ack_d;
  logic              cpu_hold_n_d;
  logic              done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CHECK;
      cnt_q      <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ack        <= 1'b0;
      cpu_hold_n <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ram_we     <= ram_we_d;
      ram_addr   <= ram_addr_d;
      ram_wdata  <= ram_wdata_d;
      ack        <= ack_d;
      cpu_hold_n <= cpu_hold_n_d;
      done       <= done_d;
    end
  end

  // Outputs are registered from the next state so they align with state_q.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr;
    ram_wdata_d  = ram_wdata;
    ack_d        = ack;
    cpu_hold_n_d = 1'b0;
    done_d       = done;

    case (state_q)
      CHECK: begin
        if (cnt_q == CNT_W'(SYNC_STAGES)) begin
          state_d = load_s ? WAIT_HI : RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_HI: begin
        if (!load_s) begin
          state_d = RUN;
        end else if (strobe_rise_c) begin
          ram_wdata_d = data_in;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        ack_d   = 1'b1;
        state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!load_s) begin
          ack_d   = 1'b0;
          state_d = RUN;
        end else if (!strobe_s) begin
          ack_d      = 1'b0;
          ram_addr_d = ram_addr + ADDR_W'(1);
          if (ram_addr == LAST_ADDR) begin
            done_d  = 1'b1;
            state_d = RUN;
          end else begin
            state_d = WAIT_HI;
          end
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CHECK;
      end
    endcase

    ram_we_d     = (state_d == WRITE);
    cpu_hold_n_d = (state_d == RUN);
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: skip, full load, latency, held strobe,
// abort and reset mid-load.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_en;
  logic       strobe;
  logic [7:0] data_in;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ack;
  logic       cpu_hold_n;
  logic       done;

  int checks   = 0;
  int failures = 0;

  int         wr_cnt  = 0;
  int         dbl_we  = 0;
  logic       we_prev = 1'b0;
  logic [3:0] wr_addr [256];
  logic [7:0] wr_data [256];
  int         base;

  program_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .strobe     (strobe),
    .data_in    (data_in),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ack        (ack),
    .cpu_hold_n (cpu_hold_n),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Log every RAM write and flag back-to-back write pulses.
  always @(posedge clk) begin
    if (ram_we) begin
      wr_addr[wr_cnt] <= ram_addr;
      wr_data[wr_cnt] <= ram_wdata;
      wr_cnt          <= wr_cnt + 1;
      if (we_prev) dbl_we <= dbl_we + 1;
    end
    we_prev <= ram_we;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"},    32'(ram_we),     32'd0);
    check({tag, "_addr"},  32'(ram_addr),   32'd0);
    check({tag, "_wdata"}, 32'(ram_wdata),  32'd0);
    check({tag, "_ack"},   32'(ack),        32'd0);
    check({tag, "_hold"},  32'(cpu_hold_n), 32'd0);
    check({tag, "_done"},  32'(done),       32'd0);
  endtask

  task automatic reset_dut(input logic le, input logic sb);
    @(negedge clk);
    rst_n   = 1'b0;
    load_en = le;
    strobe  = sb;
    data_in = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input logic val, input string tag);
    int n = 0;
    while (ack !== val && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(ack), 32'(val));
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_in = b;
    strobe  = 1'b1;
    wait_ack(1'b1, "ack_rise");
    strobe = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    load_en = 1'b0;
    strobe  = 1'b0;
    data_in = 8'h00;
    #1;
    check_reset_vals("por");

    // Skip: load_en low, CPU released after SYNC_STAGES+1 edges.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("skip_hold_early", 32'(cpu_hold_n), 32'd0);
    @(posedge clk);
    #1 check("skip_hold", 32'(cpu_hold_n), 32'd1);
    check("skip_done", 32'(done), 32'd0);
    repeat (10) @(posedge clk);
    #1 check("skip_no_we", 32'(wr_cnt), 32'd0);

    // Full load; first byte checks exact write and ack latency.
    reset_dut(1'b1, 1'b0);
    repeat (5) @(negedge clk);
    base    = wr_cnt;
    data_in = 8'h10;
    strobe  = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("lat_we_early", 32'(ram_we), 32'd0);
    @(posedge clk);
    #1 check("lat_we", 32'(ram_we), 32'd1);
    check("lat_addr", 32'(ram_addr), 32'd0);
    check("lat_wdata", 32'(ram_wdata), 32'h10);
    @(posedge clk);
    #1 check("lat_we_single", 32'(ram_we), 32'd0);
    check("lat_ack", 32'(ack), 32'd1);
    @(negedge clk);
    strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("lat_ack_held", 32'(ack), 32'd1);
    @(posedge clk);
    #1 check("lat_ack_fall", 32'(ack), 32'd0);
    check("lat_addr_inc", 32'(ram_addr), 32'd1);
    @(negedge clk);
    for (int i = 1; i < 16; i++) begin
      if (i == 15) check("full_done_early", 32'(done), 32'd0);
      send_byte(8'(8'h10 + i));
    end
    check("full_done", 32'(done), 32'd1);
    check("full_hold", 32'(cpu_hold_n), 32'd1);
    check("full_addr_wrap", 32'(ram_addr), 32'd0);
    check("full_count", 32'(wr_cnt - base), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("full_wr", 32'({wr_addr[base+i], wr_data[base+i]}), 32'({4'(i), 8'(8'h10 + i)}));
    end

    // Held strobe: strobe already high when WAIT_HI is entered.
    reset_dut(1'b1, 1'b1);
    base = wr_cnt;
    repeat (10) @(negedge clk);
    check("held_no_we", 32'(wr_cnt - base), 32'd0);
    check("held_no_ack", 32'(ack), 32'd0);
    strobe  = 1'b0;
    data_in = 8'h77;
    repeat (4) @(negedge clk);
    check("held_still_no_we", 32'(wr_cnt - base), 32'd0);
    send_byte(8'h77);
    check("held_count", 32'(wr_cnt - base), 32'd1);
    check("held_wr", 32'({wr_addr[base], wr_data[base]}), 32'({4'd0, 8'h77}));

    // Abort after 5 bytes.
    reset_dut(1'b1, 1'b0);
    repeat (5) @(negedge clk);
    base = wr_cnt;
    for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i));
    load_en = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_hold", 32'(cpu_hold_n), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ack", 32'(ack), 32'd0);
    data_in = 8'hEE;
    strobe  = 1'b1;
    repeat (6) @(negedge clk);
    strobe = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_count", 32'(wr_cnt - base), 32'd5);
    check("abort_ack_idle", 32'(ack), 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("abort_wr", 32'({wr_addr[base+i], wr_data[base+i]}), 32'({4'(i), 8'(8'hA0 + i)}));
    end

    // Reset asserted while byte at address 7 waits for strobe low.
    reset_dut(1'b1, 1'b0);
    repeat (5) @(negedge clk);
    base = wr_cnt;
    for (int i = 0; i < 7; i++) send_byte(8'(8'h30 + i));
    data_in = 8'h37;
    strobe  = 1'b1;
    wait_ack(1'b1, "midrst_ack");
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    strobe = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_count", 32'(wr_cnt - base), 32'd8);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    base = wr_cnt;
    send_byte(8'h55);
    check("reload_count", 32'(wr_cnt - base), 32'd1);
    check("reload_wr", 32'({wr_addr[base], wr_data[base]}), 32'({4'd0, 8'h55}));
    check("reload_addr", 32'(ram_addr), 32'd1);

    check("no_double_we", 32'(dbl_we), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
